// File: rtl/fsm_symbol_tx_if.sv
// Handshake and symbol bundle between a word source, the symbol transmitter
// and the downstream FSM that consumes the 2-bit symbols.
interface fsm_symbol_tx_if #(
    parameter int DATA_W = 18,
    parameter int IDX_W  = 4
);
    logic              load;
    logic [DATA_W-1:0] data;
    logic              abort;
    logic              ready;
    logic [1:0]        a;
    logic              a_valid;
    logic              last;
    logic [IDX_W-1:0]  sym_idx;
    logic              done;

    // Word source side: requests transfers, watches progress.
    modport master (
        output load, data, abort,
        input  ready, a, a_valid, last, sym_idx, done
    );

    // Transmitter side.
    modport slave (
        input  load, data, abort,
        output ready, a, a_valid, last, sym_idx, done
    );
endinterface

// File: rtl/fsm_symbol_tx.sv
// Symbol transmitter: loads a DATA_W-bit word and plays it out as 2-bit
// symbols, MSB pair first, each held for HOLD cycles, then pulses done.
module fsm_symbol_tx #(
    parameter int         DATA_W   = 18,
    parameter int         HOLD     = 4,
    parameter logic [1:0] IDLE_SYM = 2'd0,
    parameter int         IDX_W    = 4
) (
    input  logic            clk,
    input  logic            reset,
    fsm_symbol_tx_if.slave  bus
);
    localparam int NSYM   = DATA_W / 2;
    localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NSYM - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [DATA_W-1:0]   shift_reg, shift_next;
    logic [DATA_W-1:0]   shifted;
    logic [HOLD_W-1:0]   hold_reg, hold_next;
    logic [IDX_W-1:0]    idx_reg, idx_next;

    // Shift register advanced by one symbol (2 bits left, zero fill).
    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_shift
            if (gi >= 2) begin : g_move
                assign shifted[gi] = shift_reg[gi-2];
            end else begin : g_fill
                assign shifted[gi] = 1'b0;
            end
        end
    endgenerate

    // State and datapath registers; reset overrides load and abort.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            shift_reg <= '0;
            hold_reg  <= '0;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            shift_reg <= shift_next;
            hold_reg  <= hold_next;
            idx_reg   <= idx_next;
        end
    end

    // Next-state and datapath update: symbol pacing and word sequencing.
    always_comb begin
        state_next = state_reg;
        shift_next = shift_reg;
        hold_next  = hold_reg;
        idx_next   = idx_reg;
        case (state_reg)
            IDLE: begin
                // abort has no meaning here, so a coincident load simply wins
                if (bus.load) begin
                    state_next = SEND;
                    shift_next = bus.data;
                    hold_next  = HOLD_LAST;
                    idx_next   = '0;
                end
            end
            SEND: begin
                if (bus.abort) begin
                    state_next = IDLE;
                    shift_next = '0;
                    hold_next  = '0;
                    idx_next   = '0;
                end else if (hold_reg != '0) begin
                    hold_next = hold_reg - HOLD_W'(1);
                end else if (idx_reg != IDX_LAST) begin
                    shift_next = shifted;
                    idx_next   = idx_reg + IDX_W'(1);
                    hold_next  = HOLD_LAST;
                end else begin
                    // final symbol's hold expired; sym_idx reads 0 off-air
                    state_next = DONE;
                    shift_next = '0;
                    hold_next  = '0;
                    idx_next   = '0;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                shift_next = '0;
                hold_next  = '0;
                idx_next   = '0;
            end
        endcase
    end

    // Output decode from registers only, no input-to-output path.
    always_comb begin
        bus.ready   = (state_reg == IDLE);
        bus.a_valid = (state_reg == SEND);
        bus.a       = IDLE_SYM;
        if (state_reg == SEND) begin
            bus.a = shift_reg[DATA_W-1 -: 2];
        end
        bus.last    = (state_reg == SEND) && (idx_reg == IDX_LAST);
        bus.sym_idx = idx_reg;
        bus.done    = (state_reg == DONE);
    end
endmodule
